// File: rtl/des_key_stream_scheduler_if.sv
// Handshake bundle between key loader, the subkey streamer and an iterative DES datapath.
// The master drives the request and ready; the slave (the scheduler) drives status and subkeys.
interface des_key_stream_scheduler_if;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic        busy;
    logic        round_key_valid;
    logic        round_key_ready;
    logic [47:0] round_key;
    logic [3:0]  round_index;
    logic        done;

    modport master (
        output start, decrypt, key_in, round_key_ready,
        input  busy, round_key_valid, round_key, round_index, done
    );

    modport slave (
        input  start, decrypt, key_in, round_key_ready,
        output busy, round_key_valid, round_key, round_index, done
    );
endinterface

// File: rtl/des_key_stream_scheduler.sv
// Sequential DES key schedule: streams one 48-bit subkey per valid/ready handshake,
// K1..K16 with left rotations in encrypt mode or K16..K1 with right rotations in decrypt mode.
module des_key_stream_scheduler (
    input  logic                        clk,
    input  logic                        reset,
    des_key_stream_scheduler_if.slave   bus
);
    localparam int unsigned KEY_W   = 64;
    localparam int unsigned CD_W    = 56;
    localparam int unsigned HALF_W  = 28;
    localparam int unsigned SUB_W   = 48;
    localparam logic [3:0]  LAST_STEP = 4'd15;

    localparam int unsigned PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [SUB_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit n set when shift amount s[n] is 2 (n = 1..16); other bits mean a shift of 1.
    localparam logic [31:0] TWO_MASK = 32'h0000_FDF8;

    typedef enum logic [0:0] {IDLE, STREAM} state_t;

    state_t              state;
    logic [HALF_W-1:0]   c_q;
    logic [HALF_W-1:0]   d_q;
    logic [3:0]          step_q;
    logic                mode_q;
    logic                busy_q;
    logic                valid_q;
    logic                done_q;

    logic [CD_W-1:0]     pc1_key;
    logic                two_enc;
    logic                two_dec;
    logic [HALF_W-1:0]   c_next;
    logic [HALF_W-1:0]   d_next;
    logic                handshake;

    // DES bit n (1-based, MSB first) of a W-bit vector lives at index W-n.
    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CD_W; i++) begin
            r[6'(CD_W - 1 - i)] = k[6'(KEY_W - PC1_TAB[6'(i)])];
        end
        return r;
    endfunction

    function automatic logic [SUB_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUB_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < SUB_W; i++) begin
            r[6'(SUB_W - 1 - i)] = cd[6'(CD_W - PC2_TAB[6'(i)])];
        end
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] rot_l(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rot_r(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
    endfunction

    assign pc1_key   = pc1(bus.key_in);
    assign handshake = valid_q & bus.round_key_ready;
    assign two_enc   = TWO_MASK[5'(step_q) + 5'd2];
    assign two_dec   = TWO_MASK[5'd16 - 5'(step_q)];

    // Rotation applied by a non-final handshake: walks forward in encrypt, backward in decrypt.
    always_comb begin
        c_next = c_q;
        d_next = d_q;
        if (mode_q) begin
            c_next = rot_r(c_q, two_dec);
            d_next = rot_r(d_q, two_dec);
        end else begin
            c_next = rot_l(c_q, two_enc);
            d_next = rot_l(d_q, two_enc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            step_q  <= 4'd0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Encrypt pre-applies s[1] so the first pair presented is C1/D1.
                        if (bus.decrypt) begin
                            c_q <= pc1_key[CD_W-1:HALF_W];
                            d_q <= pc1_key[HALF_W-1:0];
                        end else begin
                            c_q <= rot_l(pc1_key[CD_W-1:HALF_W], 1'b0);
                            d_q <= rot_l(pc1_key[HALF_W-1:0], 1'b0);
                        end
                        mode_q  <= bus.decrypt;
                        step_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (step_q == LAST_STEP) begin
                            step_q  <= 4'd0;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            c_q    <= c_next;
                            d_q    <= d_next;
                            step_q <= step_q + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy            = busy_q;
    assign bus.round_key_valid = valid_q;
    assign bus.done            = done_q;
    assign bus.round_key       = valid_q ? pc2({c_q, d_q}) : '0;
    assign bus.round_index     = valid_q ? (mode_q ? (LAST_STEP - step_q) : step_q) : 4'd0;

endmodule

// File: tb/tb_des_key_stream_scheduler.sv
// Directed bench for des_key_stream_scheduler using the classic 133457799BBCDFF1 key schedule
// and the weak key FEFEFEFEFEFEFEFE whose subkeys are all ones.
module tb_des_key_stream_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   t0;

    des_key_stream_scheduler_if bus();

    des_key_stream_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dec;
        logic [63:0] key;
        logic [47:0] exp_key;
        logic [3:0]  exp_idx;
    } vec_t;

    localparam logic [63:0] KEY_A = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] KEY_W = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [47:0] ONES  = 48'hFFFF_FFFF_FFFF;

    logic [47:0] ka [16];
    vec_t        vecs [32];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_sub(input string name, input logic [47:0] k, input logic [3:0] idx);
        check({name, ".valid"}, 64'(bus.round_key_valid), 64'd1);
        check({name, ".key"},   64'(bus.round_key), 64'(k));
        check({name, ".index"}, 64'(bus.round_index), 64'(idx));
    endtask

    task automatic start_sched(input logic [63:0] k, input logic dec);
        bus.start   = 1'b1;
        bus.key_in  = k;
        bus.decrypt = dec;
        tick();
        bus.start   = 1'b0;
        bus.key_in  = '0;
        bus.decrypt = 1'b0;
        t0 = cyc;
    endtask

    task automatic check_done(input string name);
        check({name, ".done"},  64'(bus.done), 64'd1);
        check({name, ".busy"},  64'(bus.busy), 64'd0);
        check({name, ".valid"}, 64'(bus.round_key_valid), 64'd0);
        check({name, ".key0"},  64'(bus.round_key), 64'd0);
    endtask

    initial begin
        ka = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
               48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
               48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
               48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        for (int i = 0; i < 16; i++) begin
            vecs[i]      = '{dec: 1'b0, key: KEY_A, exp_key: ka[i],      exp_idx: 4'(i)};
            vecs[16 + i] = '{dec: 1'b1, key: KEY_A, exp_key: ka[15 - i], exp_idx: 4'(15 - i)};
        end

        reset = 1'b1;
        bus.start = 1'b0;
        bus.decrypt = 1'b0;
        bus.key_in = '0;
        bus.round_key_ready = 1'b1;
        tick();
        tick();
        check("reset.busy",  64'(bus.busy), 64'd0);
        check("reset.valid", 64'(bus.round_key_valid), 64'd0);
        check("reset.key",   64'(bus.round_key), 64'd0);
        check("reset.index", 64'(bus.round_index), 64'd0);
        check("reset.done",  64'(bus.done), 64'd0);
        reset = 1'b0;
        tick();

        // Table-driven encrypt then decrypt of KEY_A with ready held high.
        for (int i = 0; i < 32; i++) begin
            if (i % 16 == 0) start_sched(vecs[i].key, vecs[i].dec);
            expect_sub($sformatf("table[%0d]", i), vecs[i].exp_key, vecs[i].exp_idx);
            check($sformatf("table[%0d].busy", i), 64'(bus.busy), 64'd1);
            tick();
            if (i % 16 == 15) begin
                check_done($sformatf("table_end[%0d]", i));
                tick();
                check("table.done_pulse", 64'(bus.done), 64'd0);
            end
        end

        // Backpressure: ready withdrawn for 3 cycles after the 5th subkey.
        start_sched(KEY_A, 1'b0);
        for (int k = 0; k < 16; k++) begin
            expect_sub($sformatf("bp[%0d]", k), ka[k], 4'(k));
            if (k == 4) begin
                bus.round_key_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    expect_sub($sformatf("bp_hold[%0d]", s), ka[4], 4'd4);
                    check("bp_hold.done", 64'(bus.done), 64'd0);
                end
                bus.round_key_ready = 1'b1;
            end
            tick();
        end
        check_done("bp_end");
        check("bp.latency", 64'(cyc - t0), 64'd19);
        tick();

        // A start with another key mid-stream must be ignored.
        start_sched(KEY_A, 1'b0);
        for (int k = 0; k < 16; k++) begin
            expect_sub($sformatf("ign[%0d]", k), ka[k], 4'(k));
            if (k == 7) begin
                bus.start = 1'b1;
                bus.key_in = KEY_W;
                bus.decrypt = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            bus.key_in = '0;
            bus.decrypt = 1'b0;
        end
        check_done("ign_end");
        tick();

        // Reset while index 7 is presented aborts at once, then a restart begins at K1.
        start_sched(KEY_A, 1'b0);
        for (int k = 0; k < 7; k++) tick();
        expect_sub("rst_pre", ka[7], 4'd7);
        reset = 1'b1;
        #1;
        check("rst.valid", 64'(bus.round_key_valid), 64'd0);
        check("rst.key",   64'(bus.round_key), 64'd0);
        check("rst.index", 64'(bus.round_index), 64'd0);
        check("rst.busy",  64'(bus.busy), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rst.no_done", 64'(bus.done), 64'd0);
        check("rst.idle",    64'(bus.round_key_valid), 64'd0);
        start_sched(KEY_A, 1'b0);
        for (int k = 0; k < 16; k++) begin
            expect_sub($sformatf("rst_restart[%0d]", k), ka[k], 4'(k));
            tick();
        end
        check_done("rst_restart_end");

        // Back-to-back: start a decrypt of the weak key in the done cycle.
        bus.start = 1'b1;
        bus.key_in = KEY_W;
        bus.decrypt = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.key_in = '0;
        bus.decrypt = 1'b0;
        check("b2b.done_cleared", 64'(bus.done), 64'd0);
        check("b2b.busy", 64'(bus.busy), 64'd1);
        for (int k = 0; k < 16; k++) begin
            expect_sub($sformatf("b2b[%0d]", k), ONES, 4'(15 - k));
            tick();
        end
        check_done("b2b_end");
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
